// File: rtl/jtvigil_snd_pkg.sv
// Shared constants for the sound command buffer: FSM encoding, status bit
// positions and default sizes.
package jtvigil_snd_pkg;

    localparam int AW_DEFAULT   = 3;
    localparam int TO_W_DEFAULT = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_WAIT = 2'd2;

    // Bit positions inside the optional status byte
    localparam int STB_OVF     = 7;
    localparam int STB_TIMEOUT = 6;
    localparam int STB_FULL    = 5;
    localparam int STB_EMPTY   = 4;
    localparam int STB_CNT_LSB = 0;
    localparam int STB_CNT_W   = 4;

endpackage

// File: rtl/jtvigil_sndcmd_fifo.sv
// Synchronous command FIFO: registered write, combinational read at rd_ptr,
// (AW+1)-bit occupancy. A push while full is accepted only alongside a pop.
module jtvigil_sndcmd_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [7:0]    i_din,
    input  logic          i_pop,
    output logic [7:0]    o_dout,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_drop,
    output logic [AW:0]   o_count
);

    localparam int          DEPTH  = 2 ** AW;
    localparam logic [AW:0] C_FULL = {1'b1, {AW{1'b0}}};

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_wr_en;
    logic w_rd_en;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);
    assign w_rd_en = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_wr_en = i_push & (~w_full | w_rd_en);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_drop  = i_push & w_full & ~w_rd_en;
    assign o_count = r_count;

endmodule

// File: rtl/jtvigil_sndcmd.sv
// Sound command buffer: queues main-CPU writes and hands them to the sound
// latch one at a time, waiting for the sound CPU's IRQ-clear acknowledge.
// Optional status port/flag clearing with `define JTVIGIL_SNDCMD_STATUS_EN.
module jtvigil_sndcmd
    import jtvigil_snd_pkg::*;
#(
    parameter int AW   = AW_DEFAULT,
    parameter int TO_W = TO_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] main_dout,
    input  logic       main_wr,
    input  logic       snd_ack,
    output logic [7:0] latch_dout,
    output logic       latch_wr,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       ovf,
    output logic       timeout
`ifdef JTVIGIL_SNDCMD_STATUS_EN
    ,
    input  logic       st_rd,
    output logic [7:0] st_dout
`endif
);

    // Last counter value before the limit: WAIT lasts 2**TO_W-1 cycles
    localparam logic [TO_W-1:0] C_TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic            r_main_wr;
    logic [7:0]      r_latch_dout;
    logic            r_latch_wr;
    logic            r_ovf;
    logic            r_timeout;

    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_rd_data;
    logic            w_empty;
    logic            w_full;
    logic            w_drop;
    logic [AW:0]     w_count;
    logic            w_to_hit;

    assign w_push   = main_wr & ~r_main_wr;
    assign w_pop    = (r_state == ST_IDLE) && (w_count != '0);
    assign w_to_hit = (r_state == ST_WAIT) && !snd_ack && (r_cnt == C_TO_LAST);

    jtvigil_sndcmd_fifo #(
        .AW (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (main_dout),
        .i_pop   (w_pop),
        .o_dout  (w_rd_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_drop  (w_drop),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_main_wr    <= 1'b0;
            r_latch_dout <= 8'h00;
            r_latch_wr   <= 1'b0;
        end else begin
            r_main_wr  <= main_wr;
            r_latch_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_latch_dout <= w_rd_data;
                        r_latch_wr   <= 1'b1;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (snd_ack || w_to_hit) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky flags; a new event in the same cycle as a status read wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
`ifdef JTVIGIL_SNDCMD_STATUS_EN
            end else if (st_rd) begin
                r_ovf <= 1'b0;
`endif
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
`ifdef JTVIGIL_SNDCMD_STATUS_EN
            end else if (st_rd) begin
                r_timeout <= 1'b0;
`endif
            end
        end
    end

`ifdef JTVIGIL_SNDCMD_STATUS_EN
    always_comb begin
        st_dout                             = 8'h00;
        st_dout[STB_OVF]                    = r_ovf;
        st_dout[STB_TIMEOUT]                = r_timeout;
        st_dout[STB_FULL]                   = w_full;
        st_dout[STB_EMPTY]                  = w_empty;
        st_dout[STB_CNT_LSB +: STB_CNT_W]   = STB_CNT_W'(w_count);
    end
`endif

    assign latch_dout = r_latch_dout;
    assign latch_wr   = r_latch_wr;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign ovf        = r_ovf;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_jtvigil_sndcmd.sv
// Scoreboard bench for jtvigil_sndcmd (AW=3, TO_W=5); status checks are
// compiled in when JTVIGIL_SNDCMD_STATUS_EN is defined.
module tb_jtvigil_sndcmd;

    localparam int AW   = 3;
    localparam int TO_W = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] main_dout = 8'h00;
    logic       main_wr = 1'b0;
    logic       ack_auto = 1'b0;
    logic       ack_man = 1'b0;
    logic       snd_ack;
    logic [7:0] latch_dout;
    logic       latch_wr;
    logic       fifo_empty;
    logic       fifo_full;
    logic       ovf;
    logic       timeout;
`ifdef JTVIGIL_SNDCMD_STATUS_EN
    logic       st_rd = 1'b0;
    logic [7:0] st_dout;
`endif

    assign snd_ack = ack_auto | ack_man;

    jtvigil_sndcmd #(
        .AW   (AW),
        .TO_W (TO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .main_dout  (main_dout),
        .main_wr    (main_wr),
        .snd_ack    (snd_ack),
        .latch_dout (latch_dout),
        .latch_wr   (latch_wr),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .ovf        (ovf),
        .timeout    (timeout)
`ifdef JTVIGIL_SNDCMD_STATUS_EN
        ,
        .st_rd      (st_rd),
        .st_dout    (st_dout)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         at;     // expected cycle of latch_wr, -1 = any
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   ack_delay = -1;   // auto-ack this many cycles after latch_wr, -1 = never
    int   ack_at = -1;
    int   latches = 0;

    // Monitor: pops the scoreboard on every latch_wr and drives auto-acks
    always @(negedge clk) begin
        exp_t e;
        ack_auto = (cyc == ack_at);
        if (latch_wr === 1'b1) begin
            latches++;
            if (ack_delay > 0) ack_at = cyc + ack_delay;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_latch_wr cyc=%0d data=%h expected no strobe", cyc, latch_dout);
            end else begin
                e = exp_q.pop_front();
                if (latch_dout !== e.data) begin
                    bad++;
                    $display("FAIL latch_data cyc=%0d got=%h expected=%h", cyc, latch_dout, e.data);
                end else begin
                    $display("latch_wr cyc=%0d data=%h", cyc, latch_dout);
                end
                if (e.at >= 0) begin
                    total++;
                    if (cyc != e.at) begin
                        bad++;
                        $display("FAIL latch_cycle data=%h got cyc=%0d expected cyc=%0d", e.data, cyc, e.at);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    task automatic expect_byte(input logic [7:0] d, input int at);
        exp_t e;
        e.data = d;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [7:0] d, input int hi);
        main_dout = d;
        main_wr   = 1'b1;
        repeat (hi) @(negedge clk);
        main_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic man_ack();
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_latch_wr"},   latch_wr,   0);
        chk({tag, "_latch_dout"}, latch_dout, 0);
        chk({tag, "_empty"},      fifo_empty, 1);
        chk({tag, "_full"},       fifo_full,  0);
        chk({tag, "_ovf"},        ovf,        0);
        chk({tag, "_timeout"},    timeout,    0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d expected finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int tcyc;
        int n0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");

        // Single command, main_wr held 4 cycles, acked 10 cycles after latch_wr
        ack_delay = 10;
        t0 = cyc;
        expect_byte(8'h5A, t0 + 2);
        push(8'h5A, 4);
        repeat (12) @(negedge clk);
        chk("single_empty", fifo_empty, 1);
        chk("single_hold", latch_dout, 8'h5A);
        t0 = cyc;
        expect_byte(8'hC3, t0 + 2);
        push(8'hC3, 1);
        drain("single_drain", 20);
        repeat (12) @(negedge clk);

        // Back-to-back with immediate ack: minimum strobe spacing
        do_reset();
        ack_delay = 1;
        t0 = cyc;
        expect_byte(8'hA1, t0 + 2);
        expect_byte(8'hA2, t0 + 5);
        push(8'hA1, 1);
        push(8'hA2, 1);
        drain("spacing_drain", 20);

        // Burst of 5, each acked 2 cycles after its strobe
        do_reset();
        ack_delay = 2;
        t0 = cyc;
        for (int k = 0; k < 5; k++) expect_byte(8'(k + 1), t0 + 2 + 4 * k);
        for (int k = 0; k < 5; k++) push(8'(k + 1), 1);
        drain("burst_drain", 40);

        // Overflow: 9 pushes unacked fill the FIFO, 10th is dropped
        do_reset();
        ack_delay = -1;
        for (int k = 0; k < 9; k++) expect_byte(8'(8'h10 + k), -1);
        for (int k = 0; k < 9; k++) push(8'(8'h10 + k), 1);
        chk("ovf_full", fifo_full, 1);
        chk("ovf_before", ovf, 0);
        push(8'hEE, 1);
        chk("ovf_set", ovf, 1);
        chk("ovf_still_full", fifo_full, 1);
`ifdef JTVIGIL_SNDCMD_STATUS_EN
        chk("st_after_ovf", st_dout, 8'hA8);
        st_rd = 1'b1;
        @(negedge clk);
        st_rd = 1'b0;
        chk("st_cleared", st_dout, 8'h28);
        st_rd     = 1'b1;
        main_dout = 8'hEF;
        main_wr   = 1'b1;
        @(negedge clk);
        st_rd   = 1'b0;
        main_wr = 1'b0;
        chk("st_set_wins", ovf, 1);
        @(negedge clk);
`endif
        ack_delay = 1;
        man_ack();
        drain("ovf_drain", 100);
        repeat (5) @(negedge clk);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_no_timeout", timeout, 0);
        chk("ovf_empty_after", fifo_empty, 1);

        // Timeout: first command never acked, second follows after abandon
        do_reset();
        ack_delay = -1;
        t0 = cyc;
        expect_byte(8'h77, t0 + 2);
        expect_byte(8'h88, t0 + 35);
        push(8'h77, 1);
        push(8'h88, 1);
        tcyc = -1;
        for (int i = 0; i < 100; i++) begin
            if (timeout === 1'b1) begin
                tcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("timeout_cycle", tcyc, t0 + 34);
        drain("timeout_drain", 10);
        man_ack();
        repeat (3) @(negedge clk);
        chk("timeout_sticky", timeout, 1);

        // Reset while waiting with 3 entries queued
        ack_delay = -1;
        expect_byte(8'h31, -1);
        push(8'h31, 1);
        push(8'h32, 1);
        push(8'h33, 1);
        push(8'h34, 1);
        chk("midwait_sb", exp_q.size(), 0);
        do_reset();
        chk_reset_vals("midwait");
        n0 = latches;
        repeat (60) @(negedge clk);
        chk("midwait_no_latch", latches, n0);
        chk("midwait_empty", fifo_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
